// File: rtl/fetch_controller_if.sv
// Fetch controller bus bundle: instruction memory port,
// decode handshake, redirect input and status outputs.
interface fetch_controller_if;
  logic [31:0] mem_addr;
  logic        mem_req;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        instr_valid;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halted;
  logic        fault;
  logic [15:0] fetch_count;

  modport master (
    output mem_addr, mem_req,
    input  mem_ready, mem_rdata,
    output instr_out, pc_out, instr_valid,
    input  instr_ready,
    input  redirect_valid, redirect_pc,
    output halted, fault, fetch_count
  );

  modport slave (
    input  mem_addr, mem_req,
    output mem_ready, mem_rdata,
    input  instr_out, pc_out, instr_valid,
    output instr_ready,
    output redirect_valid, redirect_pc,
    input  halted, fault, fetch_count
  );
endinterface

// File: rtl/fetch_controller.sv
// Instruction fetch controller: one word per fetch,
// decode handshake, redirect with priority, halt on range exit.
module fetch_controller #(
  parameter int unsigned MEM_BYTES = 10,
  parameter logic [31:0] RESET_PC  = 32'h00000000
) (
  input logic                Clk,
  input logic                Rst,
  fetch_controller_if.master bus
);
  localparam logic [31:0] LIMIT = 32'(MEM_BYTES - 4);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    VALID,
    HALT
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc_q;
  logic        fault_q;
  logic [15:0] count_q;

  logic        redir;
  logic        redir_ok;
  logic        reset_ok;
  logic [32:0] pc_inc;
  logic        inc_ok;

  // redirect is ignored while still in IDLE
  assign redir    = bus.redirect_valid && (state != IDLE);
  assign redir_ok = (bus.redirect_pc[1:0] == 2'b00)
                 && (bus.redirect_pc <= LIMIT);
  assign reset_ok = (RESET_PC[1:0] == 2'b00)
                 && (RESET_PC <= LIMIT);
  // carry out of pc+4 counts as out of range
  assign pc_inc   = {1'b0, pc} + 33'd4;
  assign inc_ok   = !pc_inc[32] && (pc_inc[31:0] <= LIMIT);

  // state register
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next-state selection, redirect first
  always_comb begin
    state_nxt = state;
    if (redir) begin
      state_nxt = redir_ok ? FETCH : HALT;
    end else begin
      unique case (state)
        IDLE:  state_nxt = reset_ok ? FETCH : HALT;
        FETCH: if (bus.mem_ready) state_nxt = VALID;
        VALID: if (bus.instr_ready)
                 state_nxt = inc_ok ? FETCH : HALT;
        HALT:  state_nxt = HALT;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    bus.mem_req     = (state == FETCH);
    bus.instr_valid = (state == VALID);
    bus.halted      = (state == HALT);
  end

  assign bus.mem_addr    = pc;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_q;
  assign bus.fault       = fault_q;
  assign bus.fetch_count = count_q;

  // pc, captured instruction, fault flag and accept counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      pc      <= RESET_PC;
      instr_q <= '0;
      pc_q    <= '0;
      fault_q <= 1'b0;
      count_q <= '0;
    end else if (redir) begin
      pc <= bus.redirect_pc;
      if (bus.redirect_pc[1:0] != 2'b00)
        fault_q <= 1'b1;
      else if (redir_ok)
        fault_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: fault_q <= (RESET_PC[1:0] != 2'b00);
        FETCH: begin
          if (bus.mem_ready) begin
            instr_q <= bus.mem_rdata;
            pc_q    <= pc;
          end
        end
        VALID: begin
          if (bus.instr_ready) begin
            count_q <= count_q + 16'd1;
            pc      <= pc_inc[31:0];
          end
        end
        default: ;
      endcase
    end
  end
endmodule
